// File: rtl/riscv_single_cycle_core.sv
// Single-cycle RV32I core: fetch, decode, execute and retire one instruction per clock.
// Both memories are word-indexed arrays reachable hierarchically as IMEM.mem and DMEM.mem.

module riscv_imem #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic [AW-1:0] idx,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH] = '{default: '0};
  assign rdata = mem[idx];
endmodule

module riscv_dmem #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module riscv_single_cycle_core #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_IMM   = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_BR    = 7'b1100011,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111
  } opcode_e;

  logic [31:0] pc, next_pc, instr;
  logic [31:0] regs [32];
  logic [IAW-1:0] imem_idx;
  logic [DAW-1:0] dmem_idx;
  logic [31:0] dmem_rdata, ea;
  logic        dmem_we, rd_we, taken;
  logic [31:0] rd_val, alu_b, alu_y;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;

  riscv_imem #(.DEPTH(IMEM_DEPTH)) IMEM (.idx(imem_idx), .rdata(instr));

  riscv_dmem #(.DEPTH(DMEM_DEPTH)) DMEM (
    .clk(clk), .we(dmem_we), .idx(dmem_idx), .wdata(rs2_v), .rdata(dmem_rdata)
  );

  assign imem_idx = IAW'((pc >> 2) % IMEM_DEPTH);

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_v = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_v = (rs2 == 5'd0) ? '0 : regs[rs2];

  // EA is a word index, not a byte address
  assign ea       = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign dmem_idx = DAW'(ea % DMEM_DEPTH);

  assign alu_b = (opcode == OP_R) ? rs2_v : imm_i;

  always_comb begin
    alu_y = '0;
    case (funct3)
      3'b000: alu_y = (opcode == OP_R && instr[30]) ? rs1_v - alu_b : rs1_v + alu_b;
      3'b001: alu_y = rs1_v << alu_b[4:0];
      3'b010: alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
      3'b011: alu_y = {31'b0, rs1_v < alu_b};
      3'b100: alu_y = rs1_v ^ alu_b;
      3'b101: alu_y = instr[30] ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'b110: alu_y = rs1_v | alu_b;
      3'b111: alu_y = rs1_v & alu_b;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000: taken = rs1_v == rs2_v;
      3'b001: taken = rs1_v != rs2_v;
      3'b100: taken = $signed(rs1_v) <  $signed(rs2_v);
      3'b101: taken = $signed(rs1_v) >= $signed(rs2_v);
      3'b110: taken = rs1_v <  rs2_v;
      3'b111: taken = rs1_v >= rs2_v;
      default: taken = 1'b0;
    endcase
  end

  // Unknown opcodes fall through the defaults and behave as NOP
  always_comb begin
    next_pc = pc + 32'd4;
    rd_we   = 1'b0;
    rd_val  = alu_y;
    dmem_we = 1'b0;
    case (opcode)
      OP_R, OP_IMM: rd_we = 1'b1;
      OP_LOAD: begin
        rd_we  = 1'b1;
        rd_val = dmem_rdata;
      end
      OP_STORE: dmem_we = !rst;
      OP_BR: if (taken) next_pc = pc + imm_b;
      OP_JAL: begin
        rd_we   = 1'b1;
        rd_val  = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        rd_we   = 1'b1;
        rd_val  = pc + 32'd4;
        next_pc = (rs1_v + imm_i) & ~32'd1;
      end
      OP_LUI: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      OP_AUIPC: begin
        rd_we  = 1'b1;
        rd_val = pc + imm_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (rd_we && rd != 5'd0) regs[rd] <= rd_val;
    end
  end
endmodule

// File: tb/tb_riscv_single_cycle_core.sv
// Scoreboard bench for the single-cycle RV32I core: stimulus queues expected state,
// a negedge monitor pops and compares against registers, PC and data memory.

module tb_riscv_single_cycle_core;
  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam int K_REG = 0, K_PC = 1, K_DMEM = 2;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  chk_t sb [$];
  chk_t cur;
  logic [31:0] act;
  logic [31:0] prog [$];
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  riscv_single_cycle_core #(.IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (.clk(clk), .rst(rst));

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPR};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], ST};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], BR};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], JAL};
  endfunction

  function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction

  task automatic chk(input string nm, input int kind, input int idx, input logic [31:0] exp);
    sb.push_back('{nm, kind, idx, exp});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Load prog and DMEM[3] under reset, then release after 5 reset cycles
  task automatic boot(input logic [31:0] d3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 64; k++) begin
      dut.IMEM.mem[k] = '0;
      dut.DMEM.mem[k] = '0;
    end
    for (int k = 0; k < prog.size(); k++) dut.IMEM.mem[k] = prog[k];
    dut.DMEM.mem[3] = d3;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_dmem7(input logic [31:0] v);
    int k = 0;
    while (dut.DMEM.mem[7] !== v && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.kind)
        K_REG:   act = dut.regs[cur.idx];
        K_PC:    act = dut.pc;
        default: act = dut.DMEM.mem[cur.idx];
      endcase
      total++;
      if (act === cur.exp) passed++;
      else $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
    end
  end

  initial begin
    // Reset state
    prog = '{enc_j(0, 0)};
    boot(32'd0);
    rst = 1'b1;
    step(1);
    chk("reset_pc", K_PC, 0, 32'd0);
    chk("reset_x5", K_REG, 5, 32'd0);
    step(1);
    rst = 1'b0;

    // x0 and ALU basics, unknown opcode as NOP
    prog = '{enc_i(5, 0, 0, 0, OPI), enc_r(0, 0, 0, 0, 1), enc_i(-3, 0, 0, 2, OPI),
             enc_r(0, 1, 2, 2, 3), enc_r(32, 2, 1, 0, 4), 32'hFFFF_FFFF, enc_j(0, 0)};
    boot(32'd0);
    step(12);
    chk("alu_x0", K_REG, 0, 32'd0);
    chk("alu_x1", K_REG, 1, 32'd0);
    chk("alu_x2", K_REG, 2, 32'hFFFF_FFFD);
    chk("alu_x3_slt", K_REG, 3, 32'd1);
    chk("alu_x4_sub", K_REG, 4, 32'd3);
    chk("unknown_op_x31", K_REG, 31, 32'd0);
    chk("alu_halt_pc", K_PC, 0, 32'd24);

    // Wider ALU coverage, same-register read/write
    prog = '{enc_u(20'h80000, 1, LUI), enc_i(1024 + 4, 1, 5, 2, OPI), enc_i(4, 1, 5, 3, OPI),
             enc_i(-1, 0, 0, 4, OPI), enc_r(0, 4, 0, 3, 5), enc_r(0, 0, 4, 2, 6),
             enc_u(1, 7, AUIPC), enc_i(240, 4, 4, 8, OPI), enc_r(0, 3, 8, 7, 9),
             enc_r(0, 3, 2, 4, 10), enc_i(33, 0, 0, 11, OPI), enc_r(0, 11, 4, 1, 12),
             enc_i(-1, 0, 3, 13, OPI), enc_r(0, 5, 8, 0, 8), enc_r(32, 11, 2, 5, 14),
             enc_j(0, 0)};
    boot(32'd0);
    step(20);
    chk("lui", K_REG, 1, 32'h8000_0000);
    chk("srai", K_REG, 2, 32'hF800_0000);
    chk("srli", K_REG, 3, 32'h0800_0000);
    chk("sltu", K_REG, 5, 32'd1);
    chk("slt_neg", K_REG, 6, 32'd1);
    chk("auipc", K_REG, 7, 32'h0000_1018);
    chk("add_same_rd", K_REG, 8, 32'hFFFF_FF10);
    chk("and", K_REG, 9, 32'h0800_0000);
    chk("xor", K_REG, 10, 32'hF000_0000);
    chk("sll_shamt5", K_REG, 12, 32'hFFFF_FFFE);
    chk("sltiu", K_REG, 13, 32'd1);
    chk("sra", K_REG, 14, 32'hFC00_0000);
    chk("alu2_pc", K_PC, 0, 32'd60);

    // Control flow, stepped one instruction at a time
    prog = '{enc_i(5, 0, 0, 3, OPI), enc_b(20, 3, 3, 1), 32'h0000_0013,
             32'b0000001_00110_00111_000_01000_1100011, enc_j(8, 1), 32'h0,
             enc_i(13, 0, 0, 2, JALR), 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
             enc_j(-36, 0)};
    boot(32'd0);
    step(2);
    chk("bne_not_taken_pc", K_PC, 0, 32'd8);
    step(2);
    chk("beq_taken_pc", K_PC, 0, 32'd52);
    step(1);
    chk("jal_back_pc", K_PC, 0, 32'd16);
    step(1);
    chk("jal_pc", K_PC, 0, 32'd24);
    chk("jal_link", K_REG, 1, 32'd20);
    step(1);
    chk("jalr_pc", K_PC, 0, 32'd12);
    chk("jalr_link", K_REG, 2, 32'd28);

    // Negative JAL offset
    prog = '{enc_j(36, 0), 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
             enc_j(-12, 0)};
    boot(32'd0);
    step(1);
    chk("jal_fwd_pc", K_PC, 0, 32'd36);
    step(1);
    chk("jal_neg_pc", K_PC, 0, 32'd24);

    // Store/load round trip, word-indexed EA with modulo wrap on load
    prog = '{enc_i(85, 0, 0, 1, OPI), enc_s(5, 1, 0), enc_i(5, 0, 2, 2, LD),
             enc_i(69, 0, 2, 3, LD), enc_j(0, 0)};
    boot(32'd0);
    step(10);
    chk("sw_dmem5", K_DMEM, 5, 32'h55);
    chk("lw_x2", K_REG, 2, 32'h55);
    chk("lw_wrap_x3", K_REG, 3, 32'h55);
    chk("dmem4_untouched", K_DMEM, 4, 32'h0);
    chk("dmem6_untouched", K_DMEM, 6, 32'h0);
    chk("dmem0_untouched", K_DMEM, 0, 32'h0);

    // PC wraps past the end of IMEM; zero words are NOPs
    prog = '{32'h0, enc_i(1, 1, 0, 1, OPI)};
    boot(32'd0);
    step(130);
    chk("wrap_x1", K_REG, 1, 32'd3);
    chk("wrap_pc", K_PC, 0, 32'd520);

    // Factorial program
    prog = '{enc_i(3, 0, 2, 1, LD), enc_i(1, 0, 0, 5, OPI), enc_i(1, 0, 0, 2, OPI),
             enc_b(36, 2, 1, 0), enc_i(0, 0, 0, 6, OPI), enc_i(0, 1, 0, 7, OPI),
             enc_r(0, 5, 6, 0, 6), enc_i(-1, 7, 0, 7, OPI), enc_b(-8, 0, 7, 1),
             enc_i(0, 6, 0, 5, OPI), enc_i(-1, 1, 0, 1, OPI), enc_j(-32, 0),
             enc_s(7, 5, 0), enc_i(52, 0, 0, 0, JALR)};

    boot(32'd7);
    step(4);
    chk("fact7_beq_not_taken_pc", K_PC, 0, 32'd16);
    wait_dmem7(32'd5040);
    chk("fact7_dmem7", K_DMEM, 7, 32'd5040);
    chk("fact7_x5", K_REG, 5, 32'd5040);

    boot(32'd1);
    step(4);
    chk("fact1_beq_taken_pc", K_PC, 0, 32'd48);
    step(5);
    chk("fact1_dmem7", K_DMEM, 7, 32'd1);
    chk("fact1_x5", K_REG, 5, 32'd1);

    // Reset in the middle of the factorial loop
    boot(32'd7);
    step(40);
    rst = 1'b1;
    step(1);
    chk("midrst_pc", K_PC, 0, 32'd0);
    chk("midrst_x1", K_REG, 1, 32'd0);
    chk("midrst_x5", K_REG, 5, 32'd0);
    chk("midrst_x7", K_REG, 7, 32'd0);
    chk("midrst_dmem3_kept", K_DMEM, 3, 32'd7);
    step(1);
    chk("midrst_pc_2nd", K_PC, 0, 32'd0);
    rst = 1'b0;
    wait_dmem7(32'd5040);
    chk("midrst_fact7_dmem7", K_DMEM, 7, 32'd5040);

    step(2);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/riscv_single_cycle_core.md
Name: riscv_single_cycle_core

Overview:
- Single-cycle RV32I integer core: fetches, decodes, executes and retires one instruction per clock.
- Contains the PC, a 32x32 register file, ALU, branch/jump logic, and two internal word memories.
  - Instruction memory: instance `IMEM`, array `mem`.
  - Data memory: instance `DMEM`, array `mem`.
- Top-level compute block. Benches load programs and data, and read results, hierarchically via `IMEM.mem[i]` and `DMEM.mem[i]`.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit instruction words.
- DMEM_DEPTH, 64, number of 32-bit data words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.

Behaviour:
- Reset (sampled at posedge while rst=1):
  - PC <= 0.
  - All 32 registers <= 0.
  - IMEM and DMEM are not modified by reset.
- Memory initial contents:
  - Both memories are zero-initialized at time 0.
  - Arrays must be writable hierarchically at any time without being overwritten by the core, except by store instructions.
- Fetch:
  - Instruction = `IMEM.mem[(PC>>2) mod IMEM_DEPTH]`, combinational read.
- Retire (each posedge with rst=0):
  - PC, the rd write and any DMEM write all update together.
  - Latency is one cycle per instruction; there is no pipeline and no stalls.
- Register file:
  - Two combinational read ports, one write port.
  - x0 always reads 0; writes to x0 are discarded.
- Data memory addressing:
  - Effective address EA = rs1 + sign-extended immediate.
  - EA is used directly as the word index, modulo DMEM_DEPTH. It is not divided by 4: `lw x5,3(x0)` reads `DMEM.mem[3]`; `sw x5,7(x0)` writes `DMEM.mem[7]`.
  - Loads read combinationally.
  - Stores write the full 32-bit rs2 at posedge.
  - All load/store funct3 values are treated as full word.
- Supported instructions (standard RV32I encodings and immediates):
  - R-type: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
  - I-type ALU: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - Memory: LW, SW.
  - Branches: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - Jumps: JAL, JALR.
  - Upper-immediate: LUI, AUIPC.
- Arithmetic and immediate rules:
  - All arithmetic is 32-bit, wrapping; no overflow traps.
  - Shifts use the low 5 bits of the shift amount.
  - Immediates are sign-extended from bit 31 of the instruction.
- Next PC:
  - Default: PC+4.
  - Branch taken: PC + B-immediate. Example: encoding 0000001_00110_00111_000_01000_1100011 at PC 12 branches to 52.
  - JAL: rd <= PC+4, PC <= PC + J-immediate. Negative offsets are supported: -12 from 36 gives 24.
  - JALR: rd <= PC+4, PC <= (rs1 + imm) with bit 0 cleared.
- Unsupported or unknown opcodes execute as NOP: no register or memory write, PC+4.
- Boundary conditions:
  - PC past the end of IMEM wraps modulo depth; zero words decode as NOP.
  - Reset asserted mid-program returns PC to 0 and clears registers on that edge. DMEM keeps its contents, and no store occurs on a reset edge.
  - A read and a write of the same register in one instruction reads the old value (e.g. `add x8,x8,x5`).

Test Plan:
- Factorial, n=7:
  - Setup: load the 14-word factorial program (lw n from DMEM[3], nested add-loop multiply, beq/jal/jalr control, sw result to DMEM[7]). Set `DMEM.mem[3]=7`. Hold rst high for 5 cycles, then release.
  - Required: `DMEM.mem[7]=5040` before 100 us.
- Factorial, n=1:
  - Setup: same program with `DMEM.mem[3]=1`.
  - Required: the first beq is taken; `DMEM.mem[7]=1`; x5=1.
- x0 and ALU checks:
  - Program `addi x0,x0,5; add x1,x0,x0; addi x2,x0,-3; slt x3,x2,x1; sub x4,x1,x2`.
  - Required: x0=0, x1=0, x2=0xFFFFFFFD, x3=1, x4=3.
- Control flow:
  - `bne` not taken: PC advances by 4.
  - `jal x1,8` at PC 16: x1=20, PC=24.
  - `jalr x2,13(x0)`: PC=12 (bit 0 cleared), x2 = old PC+4.
- Store/load round trip:
  - Program `addi x1,x0,0x55; sw x1,5(x0); lw x2,5(x0)`.
  - Required: `DMEM.mem[5]=0x55`, x2=0x55; no other DMEM word changes.
- Reset mid-run:
  - Assert rst during the factorial loop for 2 cycles, then release.
  - Required: PC=0 and registers=0 while rst is high; the program restarts and again produces 5040 in `DMEM.mem[7]`.
